path_replay_buffer: RTL
=======================

// Module: path_replay_buffer
// PURPOSE
//   Captures the generated Monte-Carlo path stream (DAY samples x N paths, 12-bit) from the path generator
//   output and replays it, one word per cycle, into the pricing engine's path input.
//   Restarts the replay from word 0 whenever the pricing engine raises resend.
//   Sits between the chip's valid/out path stream and its in/resend pricing interface.
// PARAMETERS
//   DAY    8     samples per path
//   N      256   paths per batch
//   DW     12    sample width (bits)
//   DEPTH  DAY*N words stored (2048)
//   AW     11    address width, clog2(DEPTH)
// PORTS
//   clk        in   1    system clock, all logic on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   mode       in   2    0 IDLE, 1 param, 2 sobol/generate, 3 pricing (same encoding as chip state input)
//   wr_valid   in   1    path sample valid from generator
//   wr_data    in   DW   path sample
//   resend     in   1    pricing engine requests the batch again from word 0
//   rd_valid   out  1    rd_data holds a replayed sample this cycle
//   rd_data    out  DW   replayed sample, feeds pricing path input
//   full       out  1    DEPTH words captured
//   overflow   out  1    sticky: wr_valid seen while full
//   pass_done  out  1    1-cycle pulse after last word of a replay pass
// BEHAVIOUR
//   Reset (async, rst_n=0): FSM=S_IDLE; wr_cnt=0, rd_ptr=0; rd_valid=0, rd_data=0, full=0, overflow=0, pass_done=0.
//   Memory contents are not reset; they are never read before being written in the current batch.
//   FSM states: S_IDLE, S_FILL, S_REPLAY, S_HOLD.
//   - S_IDLE: wr_cnt=0, rd_ptr=0, flags clear. mode==2 -> S_FILL.
//   - S_FILL: each cycle with wr_valid=1 writes mem[wr_cnt]<=wr_data, wr_cnt++.
//     full=1 registered in the cycle after the DEPTH-th write.
//     wr_valid while full: no write, wr_cnt unchanged, overflow<=1 (sticky until S_IDLE).
//     mode==3 with wr_cnt>0 -> S_REPLAY, rd_ptr=0. mode==3 with wr_cnt==0 -> stay in S_FILL, rd_valid=0.
//   - S_REPLAY: registered read, 1-cycle latency: rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr++.
//     First rd_valid occurs the cycle after S_REPLAY is entered.
//     Exactly wr_cnt consecutive words per pass, no bubbles.
//     After issuing the word at rd_ptr==wr_cnt-1 -> S_HOLD; pass_done=1 during the cycle that word is valid.
//   - S_HOLD: rd_valid=0, rd_data holds last value.
//     resend=1 -> S_REPLAY with rd_ptr=0. pass_done=0.
//   resend in S_REPLAY: rd_ptr<=0 next cycle; current registered word still presented.
//     Next valid word is word 0. No pass_done for the aborted pass.
//     resend in the same cycle as the last word: restart wins, pass_done suppressed.
//   resend in S_IDLE/S_FILL: ignored.
//   mode==0 from any state -> S_IDLE next cycle; outputs/flags cleared as at reset.
//     An in-flight replay is aborted; rd_valid=0 from the next cycle.
//   mode==1 or 2 while in S_REPLAY/S_HOLD: no effect (only mode==0 ends a batch).
//   wr_valid outside S_FILL: ignored, no overflow.
//   wr_cnt is AW+1 bits so DEPTH is representable. rd_ptr wraps only via resend/restart, never by overflow.
//   Memory: single array DEPTH x DW, 1 write port, 1 registered read port. Same-cycle read/write never occurs.
// TESTING
//   1 Fill: mode=2, 2048 wr_valid words data=i[11:0]; mode=3 -> full=1; rd_valid 1 cycle after entry,
//     rd_data=0,1,..,2047 mod 4096 contiguous; pass_done with word 2047; then rd_valid=0.
//   2 Resend mid-pass: during pass, resend at word 100 -> word 100 still shown, next valid word is 0, no pass_done.
//     Resend in S_HOLD -> full 2048-word pass again.
//   3 Overflow: 2050 wr_valid writes -> full=1, overflow=1, wr_cnt=2048, replay shows first 2048 words unchanged.
//   4 Partial batch: 10 writes then mode=3 -> exactly 10 words replayed, pass_done on 10th.
//     mode=3 with 0 writes -> rd_valid stays 0.
//   5 Abort: mode=0 mid-replay -> rd_valid=0 next cycle, full/overflow cleared;
//     new mode=2 batch of 16 words replays new data only.
//   6 Async reset asserted mid-fill and mid-replay -> all outputs 0 immediately, FSM S_IDLE, resend ignored after.

Source files
------------

// File: rtl/path_replay_buffer.sv
// -----------------------------------------------------------------------------
// path_replay_buffer
//
// Captures one batch of Monte-Carlo path samples (DAY samples x N paths, DW
// bits each) from the path generator and replays the batch one word per cycle
// into the pricing engine. The pricing engine can restart the replay from word
// 0 at any time by raising resend.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   mode       chip state: 0 idle, 1 param, 2 sobol/generate, 3 pricing
//   wr_valid   generator sample valid
//   wr_data    generator sample
//   resend     pricing engine requests the batch again from word 0
//   rd_valid   rd_data holds a replayed sample this cycle
//   rd_data    replayed sample (holds its last value when rd_valid is low)
//   full       DEPTH words captured
//   overflow   sticky: a sample arrived while full (cleared in idle)
//   pass_done  one-cycle pulse alongside the last word of a completed pass
// -----------------------------------------------------------------------------
module path_replay_buffer #(
  parameter int DAY   = 8,
  parameter int N     = 256,
  parameter int DW    = 12,
  parameter int DEPTH = DAY * N,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          resend,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          overflow,
  output logic          pass_done
);

  // Chip state encodings this block reacts to; param mode (1) has no effect.
  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_GEN   = 2'd2;
  localparam logic [1:0] MODE_PRICE = 2'd3;

  // wr_cnt carries one extra bit so that a completely filled buffer (DEPTH
  // words) is representable and distinguishable from an empty one.
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_REPLAY,
    S_HOLD
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q,     state_d;
  logic [AW:0]   wr_cnt_q,    wr_cnt_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic          rd_valid_q,  rd_valid_d;
  logic [DW-1:0] rd_data_q,   rd_data_d;
  logic          full_q,      full_d;
  logic          overflow_q,  overflow_d;
  logic          pass_done_q, pass_done_d;

  // Sample storage and its port signals.
  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_rdata;

  logic          at_capacity;
  logic          last_word;

  assign at_capacity = (wr_cnt_q == DEPTH_CNT);
  // The word being issued is the final one of the captured batch.
  assign last_word   = ({1'b0, rd_ptr_q} == (wr_cnt_q - (AW+1)'(1)));
  assign mem_waddr   = wr_cnt_q[AW-1:0];
  // Read and write never target the buffer in the same cycle (fill and
  // replay are distinct states), so no read-during-write handling is needed.
  assign mem_rdata   = mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given a default first so that no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    pass_done_d = 1'b0;
    mem_we      = 1'b0;

    if (mode == MODE_IDLE) begin
      // Idle ends the batch from any state and clears everything as reset
      // does; an in-flight replay stops on the next cycle.
      state_d    = S_IDLE;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      rd_data_d  = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mode == MODE_GEN) begin
            state_d = S_FILL;
          end
        end

        S_FILL: begin
          if (wr_valid) begin
            if (at_capacity) begin
              overflow_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wr_cnt_d = wr_cnt_q + (AW+1)'(1);
            end
          end
          // full is a registered image of the count, so it rises the cycle
          // after the DEPTH-th write.
          full_d = (wr_cnt_d == DEPTH_CNT);
          // An empty batch is never replayed; stay here until data arrives.
          if ((mode == MODE_PRICE) && (wr_cnt_q != '0)) begin
            state_d  = S_REPLAY;
            rd_ptr_d = '0;
          end
        end

        S_REPLAY: begin
          // Every cycle in this state issues one word, so a pass is exactly
          // wr_cnt contiguous words with no bubbles.
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rdata;
          if (resend) begin
            // The word being issued now is still presented; the one after it
            // is word 0. Restart takes priority over ending the pass, so an
            // aborted pass never pulses pass_done.
            rd_ptr_d = '0;
          end else if (last_word) begin
            state_d     = S_HOLD;
            pass_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end

        S_HOLD: begin
          if (resend) begin
            state_d  = S_REPLAY;
            rd_ptr_d = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      pass_done_q <= pass_done_d;
    end
  end

  // NOTE: the sample array has no reset; a word is only read after it has been
  // written in the current batch, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wr_data;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign pass_done = pass_done_q;

endmodule
